// File: rtl/axi4_pkg.sv
// Shared types and constants for the AXI4 SRAM responder: burst encodings,
// response codes and the write/read channel state enums.
package axi4_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi4_sram_slave_if.sv
// AXI4 bus bundle between a master and the SRAM responder. The master modport
// drives requests and write data; the slave modport drives readies and responses.
interface axi4_sram_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int W_ID_LEN   = 4,
  parameter int R_ID_LEN   = 4
);

  // Write address channel
  logic [W_ID_LEN-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWLOCK;
  logic [3:0]              AWCACHE;
  logic [2:0]              AWPORT;
  logic                    AWVALID;
  logic                    AWREADY;

  // Write data channel
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  // Write response channel
  logic [W_ID_LEN-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  // Read address channel
  logic [R_ID_LEN-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARLOCK;
  logic [3:0]              ARCACHE;
  logic [2:0]              ARPORT;
  logic                    ARVALID;
  logic                    ARREADY;

  // Read data channel
  logic [R_ID_LEN-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [DATA_WIDTH/8-1:0] RSTRB;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPORT, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPORT, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RSTRB, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWLOCK, AWCACHE, AWPORT, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARLOCK, ARCACHE, ARPORT, ARVALID,
    output ARREADY,
    output RID, RDATA, RSTRB, RLAST, RVALID,
    input  RREADY
  );

endinterface

// File: rtl/axi4_burst_addr.sv
// Next-beat address generator for one AXI4 channel. FIXED holds the address,
// INCR steps by the beat size, WRAP steps within an aligned window of
// (len+1)*beat bytes. Illegal WRAP lengths and the reserved encoding act as INCR.
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [7:0]            len_i,
  input  logic [2:0]            size_i,
  input  logic [1:0]            burst_i,
  output logic [ADDR_WIDTH-1:0] nextAddr_o
);

  logic [ADDR_WIDTH-1:0] beatBytes;
  logic [ADDR_WIDTH-1:0] incrAddr;
  logic [ADDR_WIDTH-1:0] wrapMask;
  logic                  wrapLenOk;

  // Compute the incremented address and, for legal WRAP lengths, fold it back into the window
  always_comb begin
    beatBytes  = ADDR_WIDTH'(1) << size_i;
    incrAddr   = addr_i + beatBytes;
    wrapLenOk  = (len_i == 8'd1) || (len_i == 8'd3) || (len_i == 8'd7) || (len_i == 8'd15);
    wrapMask   = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);
    nextAddr_o = incrAddr;
    case (burst_t'(burst_i))
      FIXED: nextAddr_o = addr_i;
      WRAP: begin
        if (wrapLenOk) begin
          nextAddr_o = (addr_i & ~wrapMask) | (incrAddr & wrapMask);
        end
      end
      default: nextAddr_o = incrAddr;
    endcase
  end

endmodule

// File: rtl/axi4_sram_slave.sv
// AXI4 memory responder backed by a register array of DEPTH words. Write and
// read channels run independent FSMs, each with one burst in flight.
module axi4_sram_slave
  import axi4_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    W_ID_LEN   = 4,
  parameter int                    R_ID_LEN   = 4,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input logic              clk,
  input logic              rst_n,
  axi4_sram_slave_if.slave bus
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT = $clog2(STRB_WIDTH);
  localparam int IDX_WIDTH  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // An address is in error when it lies below the base or past the last word
  function automatic logic beatOob(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH:0] offs;
    offs = {1'b0, a} - {1'b0, BASE_ADDR};
    return offs[ADDR_WIDTH] || ((offs[ADDR_WIDTH-1:0] >> BYTE_SHIFT) >= ADDR_WIDTH'(DEPTH));
  endfunction

  function automatic logic [IDX_WIDTH-1:0] wordIdx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] offs;
    offs = a - BASE_ADDR;
    return IDX_WIDTH'(offs >> BYTE_SHIFT);
  endfunction

  // A beat wider than the data bus cannot be served at all
  function automatic logic sizeTooBig(input logic [2:0] s);
    return s > 3'(BYTE_SHIFT);
  endfunction

  // ---------------- write channel ----------------
  w_state_t              wState_q, wState_d;
  logic                  awReady_q, awReady_d;
  logic                  wReady_q, wReady_d;
  logic                  bValid_q, bValid_d;
  logic [W_ID_LEN-1:0]   bId_q, bId_d;
  logic [1:0]            bResp_q, bResp_d;
  logic [W_ID_LEN-1:0]   wId_q, wId_d;
  logic [ADDR_WIDTH-1:0] wAddr_q, wAddr_d;
  logic [7:0]            wLen_q, wLen_d;
  logic [2:0]            wSize_q, wSize_d;
  logic [1:0]            wBurst_q, wBurst_d;
  logic [7:0]            wCnt_q, wCnt_d;
  logic                  wErr_q, wErr_d;
  logic [ADDR_WIDTH-1:0] wNextAddr;
  logic                  memWe;
  logic                  wBeatErr;
  logic                  wLastBeat;

  axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) uWrAddr (
    .addr_i     (wAddr_q),
    .len_i      (wLen_q),
    .size_i     (wSize_q),
    .burst_i    (wBurst_q),
    .nextAddr_o (wNextAddr)
  );

  // Write FSM next state: accept AW, stream W beats until counter hits len, then hold B
  always_comb begin
    wState_d  = wState_q;
    awReady_d = awReady_q;
    wReady_d  = wReady_q;
    bValid_d  = bValid_q;
    bId_d     = bId_q;
    bResp_d   = bResp_q;
    wId_d     = wId_q;
    wAddr_d   = wAddr_q;
    wLen_d    = wLen_q;
    wSize_d   = wSize_q;
    wBurst_d  = wBurst_q;
    wCnt_d    = wCnt_q;
    wErr_d    = wErr_q;
    memWe     = 1'b0;
    wBeatErr  = 1'b0;
    wLastBeat = 1'b0;
    case (wState_q)
      W_IDLE: begin
        awReady_d = 1'b1;
        if (bus.AWVALID && awReady_q) begin
          wId_d     = bus.AWID;
          wAddr_d   = bus.AWADDR;
          wLen_d    = bus.AWLEN;
          wSize_d   = bus.AWSIZE;
          wBurst_d  = bus.AWBURST;
          wCnt_d    = '0;
          wErr_d    = 1'b0;
          awReady_d = 1'b0;
          wReady_d  = 1'b1;
          wState_d  = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.WVALID && wReady_q) begin
          wBeatErr  = beatOob(wAddr_q) || sizeTooBig(wSize_q);
          wLastBeat = (wCnt_q == wLen_q);
          memWe     = !wBeatErr;
          wCnt_d    = wCnt_q + 8'd1;
          wAddr_d   = wNextAddr;
          wErr_d    = wErr_q || wBeatErr || (bus.WLAST != wLastBeat);
          if (wLastBeat) begin
            wReady_d = 1'b0;
            bValid_d = 1'b1;
            bId_d    = wId_q;
            bResp_d  = wErr_d ? RESP_SLVERR : RESP_OKAY;
            wState_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        if (bus.BREADY) begin
          bValid_d  = 1'b0;
          awReady_d = 1'b1;
          wState_d  = W_IDLE;
        end
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // Write FSM registers; reset abandons any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wState_q  <= W_IDLE;
      awReady_q <= 1'b0;
      wReady_q  <= 1'b0;
      bValid_q  <= 1'b0;
      bId_q     <= '0;
      bResp_q   <= '0;
      wId_q     <= '0;
      wAddr_q   <= '0;
      wLen_q    <= '0;
      wSize_q   <= '0;
      wBurst_q  <= '0;
      wCnt_q    <= '0;
      wErr_q    <= 1'b0;
    end else begin
      wState_q  <= wState_d;
      awReady_q <= awReady_d;
      wReady_q  <= wReady_d;
      bValid_q  <= bValid_d;
      bId_q     <= bId_d;
      bResp_q   <= bResp_d;
      wId_q     <= wId_d;
      wAddr_q   <= wAddr_d;
      wLen_q    <= wLen_d;
      wSize_q   <= wSize_d;
      wBurst_q  <= wBurst_d;
      wCnt_q    <= wCnt_d;
      wErr_q    <= wErr_d;
    end
  end

  // Byte-lane memory write; contents survive reset
  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (bus.WSTRB[b]) begin
          mem[wordIdx(wAddr_q)][b*8 +: 8] <= bus.WDATA[b*8 +: 8];
        end
      end
    end
  end

  // ---------------- read channel ----------------
  r_state_t              rState_q, rState_d;
  logic                  arReady_q, arReady_d;
  logic                  rValid_q, rValid_d;
  logic [R_ID_LEN-1:0]   rId_q, rId_d;
  logic [DATA_WIDTH-1:0] rData_q, rData_d;
  logic [STRB_WIDTH-1:0] rStrb_q, rStrb_d;
  logic                  rLast_q, rLast_d;
  logic [ADDR_WIDTH-1:0] rAddr_q, rAddr_d;
  logic [7:0]            rLen_q, rLen_d;
  logic [2:0]            rSize_q, rSize_d;
  logic [1:0]            rBurst_q, rBurst_d;
  logic [7:0]            rCnt_q, rCnt_d;
  logic [ADDR_WIDTH-1:0] rNextAddr;

  axi4_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) uRdAddr (
    .addr_i     (rAddr_q),
    .len_i      (rLen_q),
    .size_i     (rSize_q),
    .burst_i    (rBurst_q),
    .nextAddr_o (rNextAddr)
  );

  // Read FSM next state: load the first beat with the AR handshake, then the next beat on each R handshake
  always_comb begin
    rState_d  = rState_q;
    arReady_d = arReady_q;
    rValid_d  = rValid_q;
    rId_d     = rId_q;
    rData_d   = rData_q;
    rStrb_d   = rStrb_q;
    rLast_d   = rLast_q;
    rAddr_d   = rAddr_q;
    rLen_d    = rLen_q;
    rSize_d   = rSize_q;
    rBurst_d  = rBurst_q;
    rCnt_d    = rCnt_q;
    case (rState_q)
      R_IDLE: begin
        arReady_d = 1'b1;
        if (bus.ARVALID && arReady_q) begin
          rAddr_d   = bus.ARADDR;
          rLen_d    = bus.ARLEN;
          rSize_d   = bus.ARSIZE;
          rBurst_d  = bus.ARBURST;
          rCnt_d    = '0;
          rData_d   = (beatOob(bus.ARADDR) || sizeTooBig(bus.ARSIZE)) ? '0 : mem[wordIdx(bus.ARADDR)];
          rValid_d  = 1'b1;
          rId_d     = bus.ARID;
          rLast_d   = (bus.ARLEN == 8'd0);
          rStrb_d   = '1;
          arReady_d = 1'b0;
          rState_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.RREADY) begin
          if (rLast_q) begin
            rValid_d  = 1'b0;
            arReady_d = 1'b1;
            rState_d  = R_IDLE;
          end else begin
            rAddr_d = rNextAddr;
            rCnt_d  = rCnt_q + 8'd1;
            rData_d = (beatOob(rNextAddr) || sizeTooBig(rSize_q)) ? '0 : mem[wordIdx(rNextAddr)];
            rLast_d = (rCnt_d == rLen_q);
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

  // Read FSM registers; reset abandons any burst in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rState_q  <= R_IDLE;
      arReady_q <= 1'b0;
      rValid_q  <= 1'b0;
      rId_q     <= '0;
      rData_q   <= '0;
      rStrb_q   <= '0;
      rLast_q   <= 1'b0;
      rAddr_q   <= '0;
      rLen_q    <= '0;
      rSize_q   <= '0;
      rBurst_q  <= '0;
      rCnt_q    <= '0;
    end else begin
      rState_q  <= rState_d;
      arReady_q <= arReady_d;
      rValid_q  <= rValid_d;
      rId_q     <= rId_d;
      rData_q   <= rData_d;
      rStrb_q   <= rStrb_d;
      rLast_q   <= rLast_d;
      rAddr_q   <= rAddr_d;
      rLen_q    <= rLen_d;
      rSize_q   <= rSize_d;
      rBurst_q  <= rBurst_d;
      rCnt_q    <= rCnt_d;
    end
  end

  assign bus.AWREADY = awReady_q;
  assign bus.WREADY  = wReady_q;
  assign bus.BVALID  = bValid_q;
  assign bus.BID     = bId_q;
  assign bus.BRESP   = bResp_q;
  assign bus.ARREADY = arReady_q;
  assign bus.RVALID  = rValid_q;
  assign bus.RID     = rId_q;
  assign bus.RDATA   = rData_q;
  assign bus.RSTRB   = rStrb_q;
  assign bus.RLAST   = rLast_q;

  // Lock, cache and protection attributes carry no meaning for a plain memory
  logic unusedAttrs;
  assign unusedAttrs = ^{bus.AWLOCK, bus.AWCACHE, bus.AWPORT, bus.ARLOCK, bus.ARCACHE, bus.ARPORT};

endmodule
